// File: rtl/input_debounce_pkg.sv
// Purpose : shared types and helpers for the input_debounce conditioner.
// Latency : n/a (types and elaboration-time function only).
// Backpressure: n/a.
//   state_t       debounce FSM state encoding
//   ms_to_cycles  converts a millisecond duration into clock cycles
package input_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_LOW_CHK,
    S_HIGH,
    S_HIGH_CHK
  } state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned f_clk_hz,
                                               input int unsigned ms);
    return (f_clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose : two-flop synchronizer for a single asynchronous bit.
// Latency : 2 cycles from the first sampling edge to o_q.
// Backpressure: none; free-running.
//   clk    system clock
//   rst_n  asynchronous active-low reset, flops load RST_VAL
//   i_d    asynchronous input
//   o_q    synchronized output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/input_debounce.sv
// Purpose : debounces one raw pin into a clean level plus rise/fall/long-press pulses.
// Latency : level/rise at edge N+2+DB_T after the first edge sampling a change.
// Backpressure: none; pulses are one cycle wide and are not held.
//   clk, rst_n  single clock, asynchronous active-low reset
//   raw_in      raw pin, asynchronous to clk
//   level       debounced level (active-high)
//   rise/fall   one-cycle pulses on committed 0->1 / 1->0 changes
//   long_press  one-cycle pulse once per press after LONG_T cycles high
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int unsigned F_CLK_HZ      = 25_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_MS       = 1000,
  parameter bit          IN_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int unsigned DB_T   = ms_to_cycles(F_CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_T = ms_to_cycles(F_CLK_HZ, LONG_MS);
  localparam int unsigned DB_W   = $clog2(DB_T) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_T) + 1;
  localparam bit          LONG_EN = (LONG_T != 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_T - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_T);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_T == 0) ? 0 : LONG_T - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  if (DB_T < 2) begin : g_db_t_check
    $error("input_debounce: debounce window must be at least 2 cycles");
  end

  logic w_sync;
  logic w_s;
  logic w_in_high;
  logic w_rise_commit;
  logic w_fall_commit;

  state_t              r_state;
  logic [DB_W-1:0]     r_db_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_level;
  logic                r_rise;
  logic                r_fall;
  logic                r_long;

  sync_2ff #(
    .RST_VAL (IN_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (raw_in),
    .o_q   (w_sync)
  );

  // Normalise polarity so everything downstream sees active-high.
  assign w_s = w_sync ^ IN_ACTIVE_LOW;

  assign w_in_high     = (r_state == S_HIGH) || (r_state == S_HIGH_CHK);
  assign w_rise_commit = (r_state == S_LOW_CHK)  &&  w_s && (r_db_cnt == DB_LAST);
  assign w_fall_commit = (r_state == S_HIGH_CHK) && !w_s && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOW;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_long <= 1'b0;

      case (r_state)
        S_LOW: begin
          if (w_s) begin
            r_state  <= S_LOW_CHK;
            r_db_cnt <= '0;
          end
        end
        S_LOW_CHK: begin
          if (!w_s) begin
            r_state <= S_LOW;
          end else if (w_rise_commit) begin
            r_state <= S_HIGH;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end
        S_HIGH: begin
          if (!w_s) begin
            r_state  <= S_HIGH_CHK;
            r_db_cnt <= '0;
          end
        end
        S_HIGH_CHK: begin
          if (w_s) begin
            r_state <= S_HIGH;
          end else if (w_fall_commit) begin
            r_state <= S_LOW;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end
        default: r_state <= S_LOW;
      endcase

      // Hold timer runs across release glitches and saturates, so the
      // long-press pulse can only fire once per press.
      if (w_rise_commit || w_fall_commit) begin
        r_hold_cnt <= '0;
      end else if (w_in_high && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
      end

      if (LONG_EN && w_in_high && !w_fall_commit && (r_hold_cnt == HOLD_LAST)) begin
        r_long <= 1'b1;
      end
    end
  end

  assign level      = r_level;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign long_press = r_long;

endmodule
